phoenix_rom_loader: RTL and testbench

//  Sequences the HPS ROM download into the Phoenix core's ROM regions: program, bg chars, fg chars, colour PROMs.
//  - Decodes each download byte to exactly one region write enable, with a region-local address.
//  - Checks the byte count against the expected image size.
//  - Owns core reset: held during download and for a fixed hold time afterwards, then driven by the user reset.
//  - Sits between hps_io ioctl_* and the phoenix core's dn_* / reset inputs.

---
 rtl/phoenix_loader_pkg.sv | 61 ++++++
 rtl/phoenix_rom_region_dec.sv | 28 ++
 rtl/phoenix_rom_loader.sv | 165 ++++++++++++++++
 tb/tb_phoenix_rom_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phoenix_loader_pkg.sv
// rtl/phoenix_loader_pkg.sv - shared types, sizes and region lookup for the Phoenix ROM loader
//
// Purpose: state and region enums, default ROM region sizes, and the
//          address -> region lookup used by the region decoder.
package phoenix_loader_pkg;

    localparam int PROG_SIZE_DEF   = 16384;
    localparam int BG_SIZE_DEF     = 4096;
    localparam int FG_SIZE_DEF     = 4096;
    localparam int PROM_SIZE_DEF   = 512;
    localparam int HOLD_CYCLES_DEF = 1024;

    localparam int ADDR_W  = 25;
    localparam int LOCAL_W = 14;
    localparam int CNT_W   = 17;

    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERROR} state_t;

    typedef enum logic [2:0] {R_PROG, R_BG, R_FG, R_PROM, R_NONE} region_id_t;

    typedef struct packed {
        region_id_t        id;
        logic [ADDR_W-1:0] base;
    } region_t;

    // Regions are laid out back to back: program, bg, fg, colour PROM.
    // Anything at or beyond the end of the PROM region maps to R_NONE.
    function automatic region_t region_of(input logic [ADDR_W-1:0] addr,
                                          input int prog_size,
                                          input int bg_size,
                                          input int fg_size,
                                          input int prom_size);
        region_t           r;
        logic [ADDR_W-1:0] bg_base;
        logic [ADDR_W-1:0] fg_base;
        logic [ADDR_W-1:0] prom_base;
        logic [ADDR_W-1:0] end_addr;
        bg_base   = ADDR_W'(prog_size);
        fg_base   = ADDR_W'(prog_size + bg_size);
        prom_base = ADDR_W'(prog_size + bg_size + fg_size);
        end_addr  = ADDR_W'(prog_size + bg_size + fg_size + prom_size);
        if (addr < bg_base) begin
            r.id   = R_PROG;
            r.base = '0;
        end else if (addr < fg_base) begin
            r.id   = R_BG;
            r.base = bg_base;
        end else if (addr < prom_base) begin
            r.id   = R_FG;
            r.base = fg_base;
        end else if (addr < end_addr) begin
            r.id   = R_PROM;
            r.base = prom_base;
        end else begin
            r.id   = R_NONE;
            r.base = end_addr;
        end
        return r;
    endfunction

endpackage

// File: rtl/phoenix_rom_region_dec.sv
// rtl/phoenix_rom_region_dec.sv - combinational download address to ROM region decoder
//
// Ports:
//   addr        in   25  download byte address
//   region      out  id  region the byte belongs to (R_NONE if past the image)
//   local_addr  out  14  address relative to the region base
module phoenix_rom_region_dec
    import phoenix_loader_pkg::*;
#(
    parameter int PROG_SIZE = PROG_SIZE_DEF,
    parameter int BG_SIZE   = BG_SIZE_DEF,
    parameter int FG_SIZE   = FG_SIZE_DEF,
    parameter int PROM_SIZE = PROM_SIZE_DEF
) (
    input  logic [ADDR_W-1:0]  addr,
    output region_id_t         region,
    output logic [LOCAL_W-1:0] local_addr
);

    region_t r;

    always_comb begin
        r          = region_of(addr, PROG_SIZE, BG_SIZE, FG_SIZE, PROM_SIZE);
        region     = r.id;
        local_addr = LOCAL_W'(addr - r.base);
    end

endmodule

// File: rtl/phoenix_rom_loader.sv
// rtl/phoenix_rom_loader.sv - sequences the HPS ROM download into the Phoenix ROM regions
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   dn_download, dn_wr         download active, one-cycle byte strobe
//   dn_addr[24:0], dn_data[7:0] download byte address and data
//   user_reset                 menu/button reset
//   wr_addr[13:0], wr_data[7:0] region-local write address and data
//   prog_we, bg_we, fg_we, prom_we  one-hot region write enables
//   core_reset                 reset to the Phoenix core
//   load_ok, load_err          result of the last download
module phoenix_rom_loader
    import phoenix_loader_pkg::*;
#(
    parameter int PROG_SIZE   = PROG_SIZE_DEF,
    parameter int BG_SIZE     = BG_SIZE_DEF,
    parameter int FG_SIZE     = FG_SIZE_DEF,
    parameter int PROM_SIZE   = PROM_SIZE_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dn_download,
    input  logic               dn_wr,
    input  logic [ADDR_W-1:0]  dn_addr,
    input  logic [7:0]         dn_data,
    input  logic               user_reset,
    output logic [LOCAL_W-1:0] wr_addr,
    output logic [7:0]         wr_data,
    output logic               prog_we,
    output logic               bg_we,
    output logic               fg_we,
    output logic               prom_we,
    output logic               core_reset,
    output logic               load_ok,
    output logic               load_err
);

    localparam int TOTAL  = PROG_SIZE + BG_SIZE + FG_SIZE + PROM_SIZE;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    state_t             state;
    state_t             state_next;
    logic               dl_q;
    logic               dl_rise;
    logic               dl_fall;
    logic               accept;
    logic [CNT_W-1:0]   byte_cnt;
    logic [CNT_W-1:0]   byte_cnt_next;
    logic               ovf;
    logic               ovf_next;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_cnt_next;
    region_id_t         region;
    logic [LOCAL_W-1:0] local_addr;

    phoenix_rom_region_dec #(
        .PROG_SIZE (PROG_SIZE),
        .BG_SIZE   (BG_SIZE),
        .FG_SIZE   (FG_SIZE),
        .PROM_SIZE (PROM_SIZE)
    ) u_dec (
        .addr       (dn_addr),
        .region     (region),
        .local_addr (local_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        dl_rise       = dn_download & ~dl_q;
        dl_fall       = ~dn_download & dl_q;
        accept        = (state == LOAD) && dn_wr;
        state_next    = state;
        hold_cnt_next = hold_cnt;
        byte_cnt_next = byte_cnt;
        if (accept && (byte_cnt != '1)) begin
            byte_cnt_next = byte_cnt + CNT_W'(1);
        end
        ovf_next = ovf | (accept && (region == R_NONE));

        if (dl_rise) begin
            // A fresh download restarts from any state, discarding earlier status.
            state_next    = LOAD;
            byte_cnt_next = '0;
            ovf_next      = 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    // The size check uses the _next values so a strobe that
                    // coincides with the falling edge of dn_download counts.
                    if (dl_fall) begin
                        if ((byte_cnt_next == CNT_W'(TOTAL)) && !ovf_next) begin
                            state_next    = HOLD;
                            hold_cnt_next = HOLD_W'(HOLD_CYCLES);
                        end else begin
                            state_next = ERROR;
                        end
                    end
                end
                HOLD: begin
                    if (user_reset) begin
                        hold_cnt_next = HOLD_W'(HOLD_CYCLES);
                    end else if (hold_cnt == '0) begin
                        state_next = RUN;
                    end else begin
                        hold_cnt_next = hold_cnt - HOLD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_q       <= 1'b0;
            byte_cnt   <= '0;
            ovf        <= 1'b0;
            hold_cnt   <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            prog_we    <= 1'b0;
            bg_we      <= 1'b0;
            fg_we      <= 1'b0;
            prom_we    <= 1'b0;
            core_reset <= 1'b1;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            dl_q     <= dn_download;
            byte_cnt <= byte_cnt_next;
            ovf      <= ovf_next;
            hold_cnt <= hold_cnt_next;
            prog_we  <= accept && (region == R_PROG);
            bg_we    <= accept && (region == R_BG);
            fg_we    <= accept && (region == R_FG);
            prom_we  <= accept && (region == R_PROM);
            if (accept) begin
                wr_addr <= local_addr;
                wr_data <= dn_data;
            end
            // In RUN this registers user_reset, giving the one-clock follow delay.
            core_reset <= (state_next == RUN) ? user_reset : 1'b1;
            if (dl_rise) begin
                load_ok  <= 1'b0;
                load_err <= 1'b0;
            end else begin
                if (state_next == HOLD) begin
                    load_ok <= 1'b1;
                end
                if (state_next == ERROR) begin
                    load_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_phoenix_rom_loader.sv
// tb/tb_phoenix_rom_loader.sv - scoreboard testbench for phoenix_rom_loader
module tb_phoenix_rom_loader;

    localparam int TOTAL = 25088;
    localparam int HOLD  = 1024;

    logic        clk;
    logic        reset;
    logic        dn_download;
    logic        dn_wr;
    logic [24:0] dn_addr;
    logic [7:0]  dn_data;
    logic        user_reset;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        prog_we;
    logic        bg_we;
    logic        fg_we;
    logic        prom_we;
    logic        core_reset;
    logic        load_ok;
    logic        load_err;

    phoenix_rom_loader dut (
        .clk         (clk),
        .reset       (reset),
        .dn_download (dn_download),
        .dn_wr       (dn_wr),
        .dn_addr     (dn_addr),
        .dn_data     (dn_data),
        .user_reset  (user_reset),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .prog_we     (prog_we),
        .bg_we       (bg_we),
        .fg_we       (fg_we),
        .prom_we     (prom_we),
        .core_reset  (core_reset),
        .load_ok     (load_ok),
        .load_err    (load_err)
    );

    typedef struct {
        int region;
        int laddr;
        int data;
        int cyc;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;
    int  bases[4] = '{0, 16384, 20480, 24576};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: regions laid out back to back from address 0.
    function automatic int ref_region(input int a);
        if (a < 16384) return 0;
        if (a < 20480) return 1;
        if (a < 24576) return 2;
        return 3;
    endfunction

    // Monitor: pops the scoreboard on every write pulse.
    int  mon_n;
    int  mon_r;
    wr_t mon_e;
    always @(negedge clk) begin
        mon_n = int'(prog_we) + int'(bg_we) + int'(fg_we) + int'(prom_we);
        if (mon_n != 0) begin
            check("we_onehot", mon_n, 1);
            mon_r = prog_we ? 0 : bg_we ? 1 : fg_we ? 2 : 3;
            if (exp_q.size() == 0) begin
                check("unexpected_we_region", mon_r, -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("we_region", mon_r, mon_e.region);
                check("wr_addr", int'(wr_addr), mon_e.laddr);
                check("wr_data", int'(wr_data), mon_e.data);
                check("we_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int a, input bit fall_too);
        int d;
        d = int'($urandom_range(0, 255));
        dn_wr   = 1'b1;
        dn_addr = 25'(a);
        dn_data = 8'(d);
        if (fall_too) dn_download = 1'b0;
        if (a < TOTAL) exp_q.push_back('{ref_region(a), a - bases[ref_region(a)], d, cyc + 1});
        tick();
        dn_wr = 1'b0;
    endtask

    task automatic begin_download();
        dn_download = 1'b1;
        tick();
        check("load_entry_core_reset", int'(core_reset), 1);
        check("load_entry_load_ok", int'(load_ok), 0);
        check("load_entry_load_err", int'(load_err), 0);
    endtask

    // n sequential bytes from address 0, with occasional idle gaps.
    task automatic stream(input int n, input bit coincident, output int fall_cyc);
        for (int i = 0; i < n; i++) begin
            strobe(i, coincident && (i == n - 1));
            if ($urandom_range(0, 99) == 0) tick();
        end
        if (!coincident) begin
            dn_download = 1'b0;
            tick();
        end
        fall_cyc = cyc;
    endtask

    task automatic wait_release(input int expect_cyc, input string name);
        int guard;
        guard = 0;
        while (core_reset === 1'b1 && guard < 3000) begin
            tick();
            guard++;
        end
        check(name, cyc, expect_cyc);
    endtask

    task automatic check_drained(input string name);
        tick();
        tick();
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #(1500000);
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int fall_cyc;
        int u;
        int ur_edge;
        int lows;

        reset       = 1'b1;
        dn_download = 1'b0;
        dn_wr       = 1'b0;
        dn_addr     = '0;
        dn_data     = '0;
        user_reset  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset: core held, nothing loaded.
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        for (int i = 0; i < 50; i++) tick();
        check("idle_core_reset", int'(core_reset), 1);
        check("idle_load_ok", int'(load_ok), 0);
        check("idle_load_err", int'(load_err), 0);

        // Full image, last byte coincident with the download fall.
        begin_download();
        stream(TOTAL, 1'b1, fall_cyc);
        check("good1_load_ok", int'(load_ok), 1);
        check("good1_load_err", int'(load_err), 0);
        check("good1_core_reset", int'(core_reset), 1);
        wait_release(fall_cyc + HOLD + 1, "good1_release_cycle");
        check_drained("good1_all_writes_seen");

        // RUN: core_reset follows user_reset one clock late; strobes ignored.
        u = 0;
        for (int i = 0; i < 40; i++) begin
            u          = int'($urandom_range(0, 1));
            user_reset = u[0];
            dn_wr      = ($urandom_range(0, 3) == 0);
            dn_addr    = 25'($urandom_range(0, TOTAL - 1));
            tick();
            check("run_core_reset_follow", int'(core_reset), u);
        end
        user_reset = 1'b0;
        dn_wr      = 1'b0;
        tick();
        check("run_load_ok_kept", int'(load_ok), 1);

        // Re-download from RUN, user_reset pulse during HOLD restarts the hold.
        begin_download();
        stream(TOTAL, 1'b0, fall_cyc);
        check("good2_load_ok", int'(load_ok), 1);
        for (int i = 0; i < int'($urandom_range(5, 400)); i++) tick();
        user_reset = 1'b1;
        ur_edge    = cyc + 1;
        tick();
        user_reset = 1'b0;
        wait_release(ur_edge + HOLD + 1, "good2_hold_restart_release");
        check_drained("good2_all_writes_seen");

        // One byte short.
        begin_download();
        stream(TOTAL - 1, 1'b0, fall_cyc);
        check("short_load_err", int'(load_err), 1);
        check("short_load_ok", int'(load_ok), 0);
        lows = 0;
        for (int i = 0; i < HOLD + 100; i++) begin
            dn_wr   = ($urandom_range(0, 7) == 0);
            dn_addr = 25'($urandom_range(0, TOTAL - 1));
            tick();
            if (core_reset !== 1'b1) lows++;
        end
        dn_wr = 1'b0;
        check("short_core_reset_low_cycles", lows, 0);
        check("short_load_err_sticky", int'(load_err), 1);
        check_drained("short_all_writes_seen");

        // Out-of-range byte: no write for it, error at the end.
        begin_download();
        strobe(32'h61FE, 1'b0);
        strobe(32'h6200, 1'b0);
        strobe(32'h61FF, 1'b0);
        dn_download = 1'b0;
        tick();
        check("ovf_load_err", int'(load_err), 1);
        check("ovf_core_reset", int'(core_reset), 1);
        check_drained("ovf_all_writes_seen");

        // Asynchronous reset in the middle of LOAD, while a write pulse is high.
        begin_download();
        for (int i = 0; i < 20; i++) strobe(100 + i, 1'b0);
        check("pre_reset_prog_we", int'(prog_we), 1);
        #6;
        reset = 1'b1;
        #1;
        check("async_prog_we", int'(prog_we), 0);
        check("async_core_reset", int'(core_reset), 1);
        check("async_wr_addr", int'(wr_addr), 0);
        check("async_load_ok", int'(load_ok), 0);
        dn_download = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("post_reset_core_reset", int'(core_reset), 1);
        check("post_reset_load_ok", int'(load_ok), 0);
        check("post_reset_load_err", int'(load_err), 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
